// File: rtl/dmem_sram_resp.sv
// dmem_sram_resp: single-port data SRAM behind a req/addr_ok, data_ok handshake.
// A request is accepted on a rising edge where req && addr_ok. data_ok pulses
// exactly LATENCY cycles later. Writes commit on the edge that enters RESP.
// Reads return the whole pre-write word.
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   req, wr        - request strobe; 1 = write, 0 = read
//   size           - 00 byte, 01 half, 10 word, 11 illegal
//   addr, wdata    - byte address; lane-aligned write data
//   addr_ok        - accepting requests (IDLE or RESP)
//   data_ok        - one-cycle response pulse
//   rdata, err     - response word / misaligned-or-illegal flag, valid with data_ok
module dmem_sram_resp #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [2:0]  CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  s_wr;
  logic [1:0]            s_size;
  logic [31:0]           s_addr;
  logic [31:0]           s_wdata;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            be;
  logic                  bad;
  logic                  we;
  logic                  unused_addr_bits;

  assign addr_ok = (state_q != WAIT);
  assign accept  = req && addr_ok;
  assign data_ok = (state_q == RESP);
  assign rdata   = rdata_q;
  assign err     = err_q;

  // The request resolved on the edge into RESP is the live input when
  // LATENCY=1 (accept and resolve share an edge), otherwise the captured copy.
  always_comb begin
    if (LATENCY == 1) begin
      s_wr    = wr;
      s_size  = size;
      s_addr  = addr;
      s_wdata = wdata;
    end else begin
      s_wr    = wr_q;
      s_size  = size_q;
      s_addr  = addr_q;
      s_wdata = wdata_q;
    end
  end

  assign idx              = s_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^s_addr[31:DEPTH_LOG2+2];

  always_comb begin
    be  = 4'b0000;
    bad = 1'b0;
    case (s_size)
      2'b00: be = 4'b0001 << s_addr[1:0];
      2'b01: begin
        be  = s_addr[1] ? 4'b1100 : 4'b0011;
        bad = s_addr[0];
      end
      2'b10: begin
        be  = 4'b1111;
        bad = (s_addr[1:0] != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          wr_d    = wr;
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit and read share the edge into RESP; the read sees pre-write data.
  // Reset gates the commit so an aborted request never writes.
  assign enter_resp = (state_d == RESP);
  assign we         = enter_resp && s_wr && !bad && !rst;

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (enter_resp) begin
      err_d = bad;
      if (!s_wr) rdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we && be[i]) mem[idx][8*i +: 8] <= s_wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_sram_resp.sv
module tb_dmem_sram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: LATENCY=2, 1: LATENCY=1, 2: LATENCY=3
  logic        rst     [3];
  logic        req     [3];
  logic        wr      [3];
  logic [1:0]  size    [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic        addr_ok [3];
  logic        data_ok [3];
  logic [31:0] rdata   [3];
  logic        err     [3];
  int          lat     [3] = '{2, 1, 3};

  int total = 0;
  int bad   = 0;

  dmem_sram_resp #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .wr(wr[0]), .size(size[0]),
    .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]),
    .data_ok(data_ok[0]), .rdata(rdata[0]), .err(err[0]));

  dmem_sram_resp #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .wr(wr[1]), .size(size[1]),
    .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]),
    .data_ok(data_ok[1]), .rdata(rdata[1]), .err(err[1]));

  dmem_sram_resp #(.DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .wr(wr[2]), .size(size[2]),
    .addr(addr[2]), .wdata(wdata[2]), .addr_ok(addr_ok[2]),
    .data_ok(data_ok[2]), .rdata(rdata[2]), .err(err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One isolated request on instance d; checks latency, response and the drop.
  task automatic xact(input int d, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_rd,
                      input string tag);
    int   n;
    logic seen;
    @(negedge clk);
    chk({tag, "_aok"}, 32'(addr_ok[d]), 32'd1);
    req[d] = 1'b1; wr[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    #1 req[d] = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (data_ok[d]) seen = 1'b1;
    end
    chk({tag, "_lat"}, seen ? 32'(n) : 32'd99, 32'(lat[d]));
    chk({tag, "_err"}, 32'(err[d]), 32'(exp_err));
    chk({tag, "_rd"}, rdata[d], exp_rd);
    @(negedge clk);
    chk({tag, "_drop"}, 32'(data_ok[d]), 32'd0);
    chk({tag, "_rd0"}, rdata[d], 32'd0);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'b00;
      addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_dok", 32'(data_ok[i]), 32'd0);
      chk("rst_rd",  rdata[i], 32'd0);
      chk("rst_err", 32'(err[i]), 32'd0);
      chk("rst_aok", 32'(addr_ok[i]), 32'd1);
      rst[i] = 1'b0;
    end

    // Word write then read
    xact(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "w10");
    xact(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "r10");
    // Byte lane merge
    xact(0, 1'b1, 2'b10, 32'h20, 32'h11223344, 1'b0, 32'h0, "w20");
    xact(0, 1'b1, 2'b00, 32'h22, 32'h00AA0000, 1'b0, 32'h0, "wb22");
    xact(0, 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, 32'h11AA3344, "r20");
    // Misaligned and illegal writes leave memory intact
    xact(0, 1'b1, 2'b10, 32'h24, 32'hCAFEF00D, 1'b0, 32'h0, "w24");
    xact(0, 1'b1, 2'b01, 32'h21, 32'hFFFFFFFF, 1'b1, 32'h0, "wh21");
    xact(0, 1'b1, 2'b11, 32'h24, 32'hFFFFFFFF, 1'b1, 32'h0, "wi24");
    xact(0, 1'b1, 2'b10, 32'h22, 32'hFFFFFFFF, 1'b1, 32'h0, "ww22");
    xact(0, 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, 32'h11AA3344, "r20b");
    xact(0, 1'b0, 2'b10, 32'h24, 32'h0, 1'b0, 32'hCAFEF00D, "r24");
    // Aligned half write into upper lanes
    xact(0, 1'b1, 2'b01, 32'h26, 32'hBEEF0000, 1'b0, 32'h0, "wh26");
    xact(0, 1'b0, 2'b10, 32'h24, 32'h0, 1'b0, 32'hBEEFF00D, "r24b");
    // Aliasing: upper address bits ignored
    xact(0, 1'b1, 2'b10, 32'h1000_0000, 32'h7, 1'b0, 32'h0, "walias");
    xact(0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0, 32'h7, "ralias");

    // Back-to-back at LATENCY=1 with req held high
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; size[1] = 2'b10; addr[1] = 32'h30; wdata[1] = 32'h5;
    @(posedge clk);
    #1 wr[1] = 1'b0; wdata[1] = 32'h0;
    @(negedge clk);
    chk("b2b_dok1", 32'(data_ok[1]), 32'd1);
    chk("b2b_rd1",  rdata[1], 32'd0);
    chk("b2b_aok",  32'(addr_ok[1]), 32'd1);
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    chk("b2b_dok2", 32'(data_ok[1]), 32'd1);
    chk("b2b_rd2",  rdata[1], 32'h5);
    chk("b2b_err2", 32'(err[1]), 32'd0);
    @(negedge clk);
    chk("b2b_idle", 32'(data_ok[1]), 32'd0);
    xact(1, 1'b1, 2'b00, 32'h33, 32'h9A000000, 1'b0, 32'h0, "l1wb");
    xact(1, 1'b0, 2'b10, 32'h30, 32'h0, 1'b0, 32'h9A000005, "l1r");

    // Reset aborts an in-flight write at LATENCY=3
    xact(2, 1'b1, 2'b10, 32'h40, 32'h1111, 1'b0, 32'h0, "l3w");
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; size[2] = 2'b10; addr[2] = 32'h40; wdata[2] = 32'h2222;
    @(posedge clk);
    #1 req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_aok", 32'(addr_ok[2]), 32'd1);
    rst[2] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (data_ok[2]) pulses++;
      @(negedge clk);
    end
    chk("abort_pulses", 32'(pulses), 32'd0);
    chk("abort_aok2", 32'(addr_ok[2]), 32'd1);
    xact(2, 1'b0, 2'b10, 32'h40, 32'h0, 1'b0, 32'h1111, "l3r");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
